// File: rtl/logic3_eval_pipe.sv
// logic3_eval_pipe: two-stage, valid-tagged evaluator of a runtime-loadable
// 3-input truth table across WIDTH independent bit lanes, with a saturating
// counter of lane-0 rising edges seen across valid results.
module logic3_eval_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic [7:0]  DEFAULT_TT = 8'h8B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             tt_load,
    input  logic [7:0]       tt_in,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic [7:0]       tt_cur,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam int unsigned TT_W = 8;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [WIDTH-1:0] r_c1;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_q;
    logic [TT_W-1:0]  r_tt;
    logic             r_q0_prev;
    logic [CNT_W-1:0] r_rise_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic             w_rise;
    logic             w_cnt_sat;

    // Stage 1: capture operands on valid, hold them otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a1       <= '0;
            r_b1       <= '0;
            r_c1       <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a1 <= a;
                r_b1 <= b;
                r_c1 <= c;
            end
        end
    end

    // Per-lane table lookup, index is {A,B,C}; uses the table as it stands now
    always_comb begin
        w_q_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_q_next[i] = r_tt[{r_a1[i], r_b1[i], r_c1[i]}];
        end
    end

    // Stage 2: register the result and its valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_q <= w_q_next;
            end
        end
    end

    // Truth-table register; a same-edge evaluation still sees the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt <= DEFAULT_TT;
        end else if (tt_load) begin
            r_tt <= tt_in;
        end
    end

    assign w_rise    = r_s1_valid & w_q_next[0] & ~r_q0_prev;
    assign w_cnt_sat = (r_rise_cnt == {CNT_W{1'b1}});

    // Lane-0 history (valid results only) and saturating rise counter; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0_prev  <= 1'b0;
            r_rise_cnt <= '0;
        end else begin
            if (r_s1_valid) begin
                r_q0_prev <= w_q_next[0];
            end
            if (cnt_clr) begin
                r_rise_cnt <= '0;
            end else if (w_rise && !w_cnt_sat) begin
                r_rise_cnt <= r_rise_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign tt_cur    = r_tt;
    assign rise_cnt  = r_rise_cnt;

endmodule

// File: tb/tb_logic3_eval_pipe.sv
// Directed bench for logic3_eval_pipe: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_logic3_eval_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       tt_load;
    logic [7:0] tt_in;
    logic       cnt_clr;

    logic        out_valid;
    logic [7:0]  q;
    logic [7:0]  tt_cur;
    logic [15:0] rise_cnt;

    logic        ov2;
    logic [7:0]  q2;
    logic [7:0]  tt2;
    logic [1:0]  cnt2;

    int n_checks;
    int n_fail;

    logic [4:0] lane0_seq;
    logic       seen_valid;

    logic_eval_inst_dummy_guard u_unused_guard_never ();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic3_eval_pipe u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .tt_load  (tt_load),
        .tt_in    (tt_in),
        .cnt_clr  (cnt_clr),
        .out_valid(out_valid),
        .q        (q),
        .tt_cur   (tt_cur),
        .rise_cnt (rise_cnt)
    );

    logic3_eval_pipe #(.CNT_W(2)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .tt_load  (tt_load),
        .tt_in    (tt_in),
        .cnt_clr  (cnt_clr),
        .out_valid(ov2),
        .q        (q2),
        .tt_cur   (tt2),
        .rise_cnt (cnt2)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: checks out_valid timing and the result, leaves idle gap
    task automatic run_sample(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                              input logic [7:0] ic, input logic [7:0] exp_q);
        in_valid = 1'b1;
        a = ia; b = ib; c = ic;
        cycle();
        in_valid = 1'b0;
        check({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        cycle();
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        cycle();
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; c = '0;
        tt_load  = 1'b0;
        tt_in    = '0;
        cnt_clr  = 1'b0;
        cycle();
        cycle();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_tt_cur", 32'(tt_cur), 32'h8B);
        check("rst_rise_cnt", 32'(rise_cnt), 32'd0);
        check("rst_sat_ov", 32'(ov2), 32'd0);
        check("rst_sat_tt", 32'(tt2), 32'h8B);
        rst_n = 1'b1;
        cycle();

        // Default table Q = ~(A|B) | (B&C)
        run_sample("dflt_zero", 8'h00, 8'h00, 8'h00, 8'hFF);
        run_sample("dflt_mix",  8'h0F, 8'hF0, 8'hCC, 8'hC0);
        run_sample("dflt_ac",   8'hFF, 8'h00, 8'hFF, 8'h00);
        check("sat_q_mirror", 32'(q2), 32'h00);

        // Table load on the edge a sample is in stage 2: old table for it, new for next
        in_valid = 1'b1;
        a = 8'h0F; b = 8'h33; c = 8'h55;
        cycle();
        tt_load = 1'b1;
        tt_in   = 8'h96;
        cycle();
        tt_load  = 1'b0;
        in_valid = 1'b0;
        check("ttsame_ov", 32'(out_valid), 32'd1);
        check("ttsame_q_old", 32'(q), 32'hD1);
        check("ttsame_tt_cur", 32'(tt_cur), 32'h96);
        cycle();
        check("ttnext_ov", 32'(out_valid), 32'd1);
        check("ttnext_q_xor", 32'(q), 32'h69);
        cycle();
        run_sample("xor", 8'h0F, 8'h33, 8'h55, 8'h69);

        // Lane-0 history so far: 1,0,0,1,1,1 -> two rises
        check("cnt_hist", 32'(rise_cnt), 32'd2);

        // Back-to-back loads: last one wins; finish on XOR
        tt_load = 1'b1;
        tt_in = 8'h00;
        cycle();
        tt_in = 8'h96;
        cycle();
        tt_load = 1'b0;
        check("tt_b2b", 32'(tt_cur), 32'h96);

        // Clear counter, then lane-0 stream 0,1,1,0,1 with idle gaps (q0_prev=1 now)
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("cnt_clr", 32'(rise_cnt), 32'd0);
        lane0_seq = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            run_sample("seq", {7'd0, lane0_seq[i]}, 8'h00, 8'h00, {7'd0, lane0_seq[i]});
            cycle();
        end
        check("cnt_seq", 32'(rise_cnt), 32'd2);

        // Four rises: 2-bit counter saturates at 3, wide counter reaches 4
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = 8'(i % 2); b = '0; c = '0;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        check("sat_cnt2", 32'(cnt2), 32'd3);
        check("sat_wide", 32'(rise_cnt), 32'd4);

        // Clear concurrent with a rise: clear wins; q0_prev still tracks
        run_sample("pre0", 8'h00, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        a = 8'h01;
        cycle();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("clr_vs_rise", 32'(rise_cnt), 32'd0);
        check("clr_vs_rise_sat", 32'(cnt2), 32'd0);
        run_sample("post1", 8'h01, 8'h00, 8'h00, 8'h01);
        check("clr_keeps_prev", 32'(rise_cnt), 32'd0);

        // Asynchronous reset between edges with a sample sitting in stage 1
        in_valid = 1'b1;
        a = 8'hFF; b = 8'h00; c = 8'h00;
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'd0);
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_tt", 32'(tt_cur), 32'h8B);
        check("arst_cnt", 32'(rise_cnt), 32'd0);
        #4;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (out_valid) seen_valid = 1'b1;
        end
        check("arst_no_ghost", 32'(seen_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// Empty module keeps the bench's guard instance resolvable.
module logic_eval_inst_dummy_guard;
endmodule

// File: doc/logic3_eval_pipe.md
Name: logic3_eval_pipe

Overview:
- Parametrised, pipelined successor to the team's 3-input combinational logic cell.
- Evaluates an arbitrary 3-input Boolean function bitwise across WIDTH lanes, selected by a runtime-loadable 8-bit truth table.
- Adds a valid-tagged 2-cycle pipeline and a saturating rising-edge event counter on lane 0.
- Sits between switch/input synchronisers and display/LED logic on the board-level datapath.

Parameters:
- WIDTH, 8, number of independent bit lanes.
- CNT_W, 16, width of the lane-0 rising-edge counter.
- DEFAULT_TT, 8'h8B, truth table loaded at reset. Encodes Q = ~(A|B) | (B&C).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a/b/c carry a sample this cycle.
- a  in  WIDTH  operand A, per lane.
- b  in  WIDTH  operand B, per lane.
- c  in  WIDTH  operand C, per lane.
- tt_load  in  1  load tt_in into the truth-table register.
- tt_in  in  8  new truth table; bit index = {A,B,C}.
- cnt_clr  in  1  synchronous clear of rise_cnt.
- out_valid  out  1  q holds a new result this cycle.
- q  out  WIDTH  registered result.
- tt_cur  out  8  current truth-table register.
- rise_cnt  out  CNT_W  count of lane-0 0->1 transitions across valid outputs.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). Registers clear immediately on rst_n=0, independent of clk.
- Reset values:
  - out_valid=0, q=0, rise_cnt=0.
  - tt_cur=DEFAULT_TT.
  - Stage-1 valid=0, stage-1 operands=0, q0_prev=0.
- Stage 1: on each clk edge, s1_valid<=in_valid. When in_valid=1, a/b/c are captured; otherwise operand registers hold.
- Stage 2: when s1_valid=1, q[i] <= tt_cur[{a1[i],b1[i],c1[i]}] for every lane i, and out_valid<=1. When s1_valid=0, out_valid<=0 and q holds its last value.
- Latency: in_valid at edge N gives out_valid=1 with q at edge N+2. Throughput is 1 sample/cycle with no back-pressure.
- Truth-table load: tt_cur<=tt_in at an edge with tt_load=1.
  - A stage-2 evaluation at that same edge uses the OLD table.
  - The new table applies from the following edge.
  - Back-to-back loads: the last one wins.
- Edge counter: evaluated at each edge where stage 2 produces a result (s1_valid=1).
  - rise = (new q[0]==1) && (q0_prev==0); q0_prev<=new q[0].
  - Non-valid cycles do not update q0_prev.
  - The first valid after reset compares against q0_prev=0.
- Counter saturates at 2^CNT_W-1; further rises are ignored.
- cnt_clr=1 sets rise_cnt<=0 and takes priority over a same-cycle increment. q0_prev is unaffected.
- Reset mid-stream: any in-flight stage-1 sample is discarded. No out_valid appears for it after rst_n deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, default table, in_valid=1 for one cycle:
  - a=00,b=00,c=00 -> q=8'hFF, out_valid pulses exactly 2 cycles later.
  - a=0F,b=F0,c=CC -> q=8'hC0.
  - a=FF,b=00,c=FF -> q=8'h00.
- Load tt_in=8'h96 (3-input XOR), then send a=0F,b=33,c=55 -> q=8'h69, tt_cur=8'h96.
- tt_load at the same edge a sample reaches stage 2 -> that sample uses 8'h8B; the next sample uses the new table.
- Valid stream with lane-0 results 0,1,1,0,1, idle gaps between samples -> rise_cnt=2. Gaps do not reset q0_prev.
- CNT_W=2, four lane-0 rises -> rise_cnt stays 3. cnt_clr concurrent with a rise -> rise_cnt=0.
- Assert rst_n=0 asynchronously (between edges) with a sample in stage 1:
  - q=0, out_valid=0, tt_cur=8'h8B immediately.
  - No out_valid appears after release.
